// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Turns a bouncy mechanical switch/button level into a clean debounced level.
// The output is meant to feed the lvl input of the level-to-pulse edge
// detector that sits downstream.
//
// A four-state Moore FSM tracks the committed level:
//   ZERO  : committed level 0, idle
//   WAIT1 : committed level 0, qualifying a rise
//   ONE   : committed level 1, idle
//   WAIT0 : committed level 1, qualifying a fall
//
// When a WAIT state is entered, a down-counter is loaded with STABLE_CYCLES-1.
// The new level commits only if the input holds that value for STABLE_CYCLES
// further samples. Any opposite sample during WAIT drops straight back to the
// stable state. A later attempt starts again from a full reload, so earlier
// stable samples give no partial credit.
//
// Optional feature, selected by the macro DEBOUNCE_SYNC_EN:
//   defined   : sw passes through a two-flop synchronizer (reset to 0) before
//               the FSM. sw may be asynchronous to clk. Every latency grows by
//               2 cycles.
//   undefined : the FSM samples sw directly. sw must be synchronous to clk.
//
// Parameters:
//   STABLE_CYCLES : number of consecutive samples at the new value required
//                   before db_level follows (legal range 1 .. 2**CNT_W)
//   CNT_W         : width of the stability counter
//
// Ports:
//   clk      : system clock, rising-edge active
//   rst      : asynchronous, active-high reset
//   sw       : raw switch level
//   db_level : debounced level, decoded from the state register
//   busy     : high while a level change is being qualified (WAIT1/WAIT0)
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_level,
  output logic busy
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  // STABLE_CYCLES may equal 2**CNT_W, so the reload is computed as
  // STABLE_CYCLES-1, which always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             sw_s;

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer. The first flop may go metastable. The second flop
  // gives it a full cycle to resolve before the FSM sees the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw;
      sync_q2 <= sync_q1;
    end
  end

  assign sw_s = sync_q2;
`else
  assign sw_s = sw;
`endif

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // In each WAIT state, an opposite sample is tested before the counter. This
  // ordering ensures that a bounce on the very cycle the counter reaches zero
  // still rejects the change. The counter is only reloaded on entry to a WAIT
  // state. It is only decremented while nonzero, so it never wraps.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_n = WAIT1;
          cnt_n   = RELOAD;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_n = ZERO;
        end else if (cnt == '0) begin
          state_n = ONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_n = WAIT0;
          cnt_n   = RELOAD;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_n = ONE;
        end else if (cnt == '0) begin
          state_n = ZERO;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        // Recovery path for a corrupted state register.
        state_n = ZERO;
        cnt_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  // Both outputs are decoded from the state register alone. They change only
  // on a clock edge or on reset, so they cannot glitch when sw changes.
  always_comb begin
    db_level = 1'b0;
    busy     = 1'b0;
    case (state)
      ZERO:    begin db_level = 1'b0; busy = 1'b0; end
      WAIT1:   begin db_level = 1'b0; busy = 1'b1; end
      ONE:     begin db_level = 1'b1; busy = 1'b0; end
      WAIT0:   begin db_level = 1'b1; busy = 1'b1; end
      default: begin db_level = 1'b0; busy = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Self-checking bench for switch_debouncer, with STABLE_CYCLES=4 and CNT_W=3.
//
// The reference model describes the debouncer by a run length instead of a
// state machine. It counts how many consecutive samples have differed from
// the committed level. Once that run exceeds STABLE_CYCLES, the level flips.
// busy is high whenever the run is nonzero.
//
// When DEBOUNCE_SYNC_EN is defined, the model first delays sw by two samples.
//
// Handshake: none. The design has a single level input and level outputs.
// Inputs change 1 time unit after a rising edge. Outputs are read there too.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int S  = 4;
  localparam int CW = 3;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = S + SYNC_D;

  logic clk;
  logic rst;
  logic sw;
  logic db_level;
  logic busy;

  int errors;
  int checks;

  // Reference model state.
  logic m_level;
  int   m_run;
  logic p1;
  logic p2;

  switch_debouncer #(
    .STABLE_CYCLES(S),
    .CNT_W        (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .db_level(db_level),
    .busy    (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void model_reset();
    m_level = 1'b0;
    m_run   = 0;
    p1      = 1'b0;
    p2      = 1'b0;
  endfunction

  // Applies one rising edge with raw input value v.
  function automatic void model_edge(input logic v);
    logic s;
    if (SYNC_D == 2) begin
      s  = p2;
      p2 = p1;
      p1 = v;
    end else begin
      s = v;
    end
    if (s != m_level) begin
      m_run = m_run + 1;
      if (m_run > S) begin
        m_level = s;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Presents v for one edge, advances the model, and returns 1 time unit
  // after the edge.
  task automatic drive(input logic v);
    sw = v;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    sw  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (db_level !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: db_level=%b busy=%b, required 0 0", db_level, busy);
    end
    rst = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      drive(1'b1);
      checks++;
      if (db_level !== ((i > LAT) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL reset_rise db_level edge %0d: got %b required %b",
                 i, db_level, (i > LAT));
      end
      checks++;
      if (busy !== ((i > SYNC_D && i <= LAT) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL reset_rise busy edge %0d: got %b required %b",
                 i, busy, (i > SYNC_D && i <= LAT));
      end
    end
  endtask

  // Drives a fixed bit pattern, LSB first, and compares each edge with the
  // model.
  task automatic run_pattern(input string name, input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      drive(pat[i]);
      checks++;
      if (db_level !== m_level || busy !== (m_run != 0)) begin
        errors++;
        $display("FAIL %s edge %0d: db_level=%b busy=%b, required %b %b",
                 name, i, db_level, busy, m_level, (m_run != 0));
      end
    end
  endtask

  task automatic test_clean_rise_fall();
    run_pattern("clean_idle", 32'h0, 6);
    run_pattern("clean_rise", 32'hFFFF_FFFF, LAT + 3);
    checks++;
    if (db_level !== 1'b1) begin
      errors++;
      $display("FAIL clean_rise_final: db_level=%b required 1", db_level);
    end
    run_pattern("clean_fall", 32'h0, LAT + 3);
    checks++;
    if (db_level !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_fall_final: db_level=%b busy=%b required 0 0", db_level, busy);
    end
  endtask

  task automatic test_bounce_reject();
    // Three highs, then a low, then a steady high: the first attempt is
    // dropped and the second must wait for a full qualification.
    run_pattern("bounce_rise", 32'b1111_1111_1111_0111, 16);
    run_pattern("bounce_tail", 32'h0, LAT + 3);
  endtask

  task automatic test_falling_bounce();
    run_pattern("fb_to_one", 32'hFFFF_FFFF, LAT + 3);
    run_pattern("fb_pulse", 32'b1111_1111_1001, 12);
    checks++;
    if (db_level !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL falling_bounce_final: db_level=%b busy=%b required 1 0", db_level, busy);
    end
  endtask

  task automatic test_glitch();
    run_pattern("glitch_rise", 32'b0000_0000_0100_0000, 16);
    checks++;
    if (db_level !== 1'b0) begin
      errors++;
      $display("FAIL glitch_final: db_level=%b required 0", db_level);
    end
  endtask

  task automatic test_reset_mid_wait();
    run_pattern("rmw_to_one", 32'hFFFF_FFFF, LAT + 3);
    run_pattern("rmw_fall", 32'h0, SYNC_D + 2);
    checks++;
    if (db_level !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmw_in_wait0: db_level=%b busy=%b required 1 1", db_level, busy);
    end
    // Assert reset between clock edges and check the outputs before the next
    // edge arrives.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (db_level !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmw_async: db_level=%b busy=%b required 0 0", db_level, busy);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_pattern("rmw_after", 32'h0, 4);
  endtask

  task automatic test_random();
    int   left;
    logic v;
    left = 0;
    v    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (left == 0) begin
        v    = $urandom_range(0, 1);
        left = $urandom_range(1, LAT + 3);
      end
      left--;
      drive(v);
      checks++;
      if (db_level !== m_level || busy !== (m_run != 0)) begin
        errors++;
        $display("FAIL random edge %0d: db_level=%b busy=%b, required %b %b",
                 i, db_level, busy, m_level, (m_run != 0));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    sw     = 1'b0;
    model_reset();
    test_reset();
    test_clean_rise_fall();
    test_bounce_reject();
    test_falling_bounce();
    test_glitch();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Debounces a bouncy mechanical switch/button input into a clean level.
- Sits directly upstream of the level-to-pulse edge detector: db_level drives the detector's lvl input.
- Four-state FSM plus a down-counter that requires the input to hold stable for a programmable number of cycles before the output level changes.

Parameters:
- STABLE_CYCLES, 1000000, cycles sw must stay at the new value before db_level follows (10 ms at 100 MHz); legal range 1 to 2^CNT_W.
- CNT_W, 20, width of the stability counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  1  raw switch level.
- db_level  output  1  debounced level, registered (Moore, decoded from the state register).
- busy  output  1  high while a level change is being qualified (WAIT1/WAIT0).

Behaviour:
- Reset (rst=1, asynchronous): state=ZERO, cnt=0, db_level=0, busy=0, synchronizer flops (if present) =0.
- sw_s denotes the sampled input: sw itself, or the synchronizer output when DEBOUNCE_SYNC_EN is defined.
- State ZERO (db_level=0, busy=0): sw_s=1 -> WAIT1, cnt<=STABLE_CYCLES-1; else stay.
- State WAIT1 (db_level=0, busy=1):
  - sw_s=0 -> ZERO (bounce rejected).
  - else cnt==0 -> ONE.
  - else cnt<=cnt-1.
- State ONE (db_level=1, busy=0): sw_s=0 -> WAIT0, cnt<=STABLE_CYCLES-1; else stay.
- State WAIT0 (db_level=1, busy=1):
  - sw_s=1 -> ONE (bounce rejected).
  - else cnt==0 -> ZERO.
  - else cnt<=cnt-1.
- sw_s==0 check in WAIT1 (and sw_s==1 in WAIT0) has priority over cnt==0.
- Latency: if sw_s is first sampled 1 at edge k and stays 1 through edge k+STABLE_CYCLES, db_level rises after edge k+STABLE_CYCLES and busy falls in the same cycle. Falling edge is symmetric.
- Any opposite sample during WAIT restarts qualification from the stable state. Counter reload happens only on entry to WAIT; no partial credit.
- STABLE_CYCLES=1: entry loads cnt=0, so the next edge commits; latency is 1 cycle after first sample.
- Counter is unsigned CNT_W bits; never decrements below 0 (leaves WAIT at 0).
- Unused state encodings recover to ZERO on the next edge.
- rst asserted mid-WAIT: immediate return to ZERO; db_level=0 even if the prior level was 1.
- db_level changes at most once per qualified transition; no glitches (registered decode).

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: sw passes through a two-flop synchronizer (both flops reset to 0, asynchronous on rst) before the FSM. All latencies grow by 2 cycles; sw may be fully asynchronous to clk.
- Undefined: FSM samples sw directly; sw must be synchronous to clk; no added latency.

Test Plan (STABLE_CYCLES=4, CNT_W=3, macro undefined unless stated):
- Reset: hold rst=1 with sw=1 -> db_level=0, busy=0; release, sw held 1 -> busy=1 after first edge, db_level=1 exactly 4 edges later, busy=0 then.
- Clean rise: sw 0->1 sampled at edge 10, held -> busy=1 after edge 10, db_level=1 after edge 14; clean fall from sample at edge 30 -> db_level=0 after edge 34.
- Bounce reject: sw=1 for edges 10-12, sw=0 at edge 13 -> db_level stays 0, busy=0 after edge 13; sw=1 again at edge 14 and held -> db_level=1 after edge 18.
- Falling bounce: in ONE, sw pulses 0 for 2 edges then 1 -> db_level stays 1 throughout, busy high 2 cycles, back to ONE.
- Reset mid-operation: db_level=1, sw->0, assert rst asynchronously at edge+2 of WAIT0 -> db_level=0, busy=0 immediately without waiting for a clock.
- DEBOUNCE_SYNC_EN defined: same stimulus as clean rise (sw change before edge 10) -> db_level=1 after edge 16; glitch of 1 cycle on raw sw -> no db_level change.
